tile_c_drain: RTL and testbench
===============================

// Module: tile_c_drain
// PURPOSE
//  Drains finished C tiles from tile_mac_pe. Snapshots the full sqDim x sqDim accumulator array on a
//  capture pulse, frees the PE for its next accumulation, then streams the tile row by row over a
//  valid/ready interface toward the result memory writer. Double-buffered; saturates each word to OutWordWidth.
// PARAMETERS
//  OutDataWidth  32  width of each tile_mac_pe accumulator word (input side)
//  OutWordWidth  16  width of each streamed word after signed saturation (<= OutDataWidth)
//  sqDim         4   tile dimension; rows per tile = words per row = sqDim
// PORTS
//  clk_i          in   1                            clock, rising edge
//  rst_i          in   1                            synchronous, active-high reset
//  capture_i      in   1                            pulse: c_in holds a finished tile, snapshot it
//  c_in           in   [sqDim][sqDim][OutDataWidth] packed signed accumulator array from tile_mac_pe
//  capture_rdy_o  out  1                            a snapshot slot is free this cycle
//  out_valid_o    out  1                            out_data_o holds a valid row
//  out_ready_i    in   1                            downstream accepts the row
//  out_data_o     out  [sqDim][OutWordWidth]        saturated row, element [c] = column c
//  out_row_o      out  $clog2(sqDim)                row index of current beat
//  out_last_o     out  1                            current beat is row sqDim-1
//  busy_o         out  1                            any snapshot held (active or pending)
//  overflow_o     out  1                            sticky: capture_i seen while capture_rdy_o=0
//  sat_o          out  1                            sticky: any streamed word was clipped
// BEHAVIOUR
//  - Reset: all outputs 0 except capture_rdy_o=1; state IDLE, row counter 0, both slots empty,
//    stickies cleared. Snapshot data regs are not reset; out_data_o is forced 0 while out_valid_o=0.
//  - Reset mid-drain aborts the tile: no further beats, no partial replay; held data discarded.
//  - Two slots: ACTIVE (being streamed), PENDING. capture_rdy_o = !pending_full.
//  - Accepted capture (capture_i & capture_rdy_o) at edge t: goes to ACTIVE if ACTIVE is empty or
//    frees at edge t (last-row handshake with PENDING empty), else to PENDING. Lossless in all cases.
//  - Dropped capture (capture_i & !capture_rdy_o): data ignored, overflow_o=1 until reset.
//  - FSM: IDLE -> DRAIN on capture into empty ACTIVE; out_valid_o=1 from the next cycle (1-cycle latency).
//    DRAIN: beat = out_valid_o & out_ready_i; on beat row++ ; on beat with row=sqDim-1:
//    PENDING full -> promote PENDING to ACTIVE, row=0, stay DRAIN, no bubble (valid stays 1);
//    else capture same cycle -> load ACTIVE, row=0, stay DRAIN; else -> IDLE, valid=0.
//  - AXI-style: while out_valid_o=1 & !out_ready_i, out_data_o/out_row_o/out_last_o held stable;
//    valid never drops without a beat. out_ready_i ignored in IDLE.
//  - out_last_o = out_valid_o & (row==sqDim-1). busy_o = active_full | pending_full.
//  - Saturation per word, signed: x > 2^(W-1)-1 -> 2^(W-1)-1; x < -2^(W-1) -> -2^(W-1); else x[W-1:0]
//    (W=OutWordWidth). Applied combinationally on the selected row; sat_o set on a beat that clipped.
//    OutWordWidth==OutDataWidth: pass-through, sat_o never sets.
//  - Throughput: one row per cycle with out_ready_i=1; back-to-back tiles stream with zero gap.
// STRUCTURE
//  - Shared package gemm_tile_pkg: drain_state_e {IDLE, DRAIN}; row index width localparam;
//    saturation min/max constants as functions of width.
//  - Sub-module sat_clip (combinational, OutDataWidth -> OutWordWidth, clip flag), instantiated sqDim
//    times on the row mux output. Snapshot regs, slot flags, FSM, row counter in this module.
// TESTING
//  1 c_in[r][c]=r*4+c, capture_i 1 cycle at t, out_ready_i=1 -> beats at t+1..t+4, row3 = {12,13,14,15},
//    out_last_o only at t+4, valid=0 at t+5, capture_rdy_o=1 throughout.
//  2 Tile from A[i][j]=i+j+1, B[i][j]=i*j+1 via tile_mac_pe; capture -> row0 = {10,30,50,70}.
//  3 Backpressure: out_ready_i toggles 1,0,0,1,... -> each row held stable while stalled, 4 beats total,
//    no duplicates/skips.
//  4 Two captures 2 cycles apart, then a third while both slots full (out_ready_i=0) -> capture_rdy_o=0,
//    overflow_o=1, exactly 8 beats emerge, second tile starts the cycle after first last beat.
//  5 c_in words 40000, -40000, 32767, -32768 (W=16) -> 32767, -32768, 32767, -32768; sat_o=1 after beat.
//  6 rst_i asserted after row 1 beat -> next cycle valid=0, busy_o=0, overflow_o=0, capture_rdy_o=1;
//    new capture restarts at row 0.

Source files
------------

// File: rtl/gemm_tile_pkg.sv
// Shared types and helpers for the GEMM tile datapath: drain FSM states,
// row-index width and signed saturation limits.
package gemm_tile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Row index needs at least one bit even for a 1x1 tile.
    function automatic int row_idx_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational signed saturation of one accumulator word down to the
// streamed word width, with a flag when the value had to be clipped.
module sat_clip
    import gemm_tile_pkg::*;
#(
    parameter int InW  = 32,
    parameter int OutW = 16
) (
    input  logic [InW-1:0]  x_i,
    output logic [OutW-1:0] y_o,
    output logic            clip_o
);

    if (OutW >= InW) begin : g_pass
        assign y_o    = OutW'(x_i);
        assign clip_o = 1'b0;
    end else begin : g_clip
        localparam longint MaxV = sat_max(OutW);
        localparam longint MinV = sat_min(OutW);
        logic signed [63:0] xs;

        always_comb begin
            xs     = 64'(signed'(x_i));
            y_o    = x_i[OutW-1:0];
            clip_o = 1'b0;
            if (xs > MaxV) begin
                y_o    = MaxV[OutW-1:0];
                clip_o = 1'b1;
            end else if (xs < MinV) begin
                y_o    = MinV[OutW-1:0];
                clip_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_c_drain.sv
// Double-buffered drain of finished C tiles: snapshot on capture, then stream
// one saturated row per handshake toward the result writer.
module tile_c_drain
    import gemm_tile_pkg::*;
#(
    parameter int OutDataWidth = 32,
    parameter int OutWordWidth = 16,
    parameter int sqDim        = 4,
    localparam int RowW        = row_idx_w(sqDim)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          capture_i,
    input  logic [sqDim-1:0][sqDim-1:0][OutDataWidth-1:0] c_in,
    output logic                                          capture_rdy_o,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [sqDim-1:0][OutWordWidth-1:0]            out_data_o,
    output logic [RowW-1:0]                               out_row_o,
    output logic                                          out_last_o,
    output logic                                          busy_o,
    output logic                                          overflow_o,
    output logic                                          sat_o
);

    typedef logic [sqDim-1:0][sqDim-1:0][OutDataWidth-1:0] tile_t;
    localparam logic [RowW-1:0] LastRow = RowW'(sqDim - 1);

    tile_t                             act_q, pend_q;
    drain_state_e                      state_q, state_d;
    logic [RowW-1:0]                   row_q, row_d;
    logic                              pend_full_q, pend_full_d;
    logic                              ovf_q, ovf_d;
    logic                              sat_q, sat_d;
    logic                              load_act_cap, load_act_pend, load_pend;
    logic                              beat, last_row, cap_acc;
    logic [sqDim-1:0]                  clip;
    logic [sqDim-1:0][OutWordWidth-1:0] row_sat;

    // The ACTIVE slot is full exactly while the FSM is draining.
    assign out_valid_o   = (state_q == DRAIN);
    assign capture_rdy_o = !pend_full_q;
    assign beat          = out_valid_o & out_ready_i;
    assign last_row      = (row_q == LastRow);
    assign cap_acc       = capture_i & capture_rdy_o;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        pend_full_d   = pend_full_q;
        ovf_d         = ovf_q | (capture_i & !capture_rdy_o);
        sat_d         = sat_q | (beat & (|clip));
        load_act_cap  = 1'b0;
        load_act_pend = 1'b0;
        load_pend     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_acc) begin
                    state_d      = DRAIN;
                    row_d        = '0;
                    load_act_cap = 1'b1;
                end
            end
            DRAIN: begin
                if (beat && last_row) begin
                    row_d = '0;
                    if (pend_full_q) begin
                        load_act_pend = 1'b1;
                        pend_full_d   = 1'b0;
                    end else if (cap_acc) begin
                        load_act_cap = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) row_d = row_q + 1'b1;
                    if (cap_acc) begin
                        load_pend   = 1'b1;
                        pend_full_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            row_q       <= '0;
            pend_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pend_full_q <= pend_full_d;
            ovf_q       <= ovf_d;
            sat_q       <= sat_d;
        end
    end

    // Snapshot storage carries no reset; slot flags decide whether it is meaningful.
    always_ff @(posedge clk_i) begin
        if (load_act_cap)       act_q <= c_in;
        else if (load_act_pend) act_q <= pend_q;
        if (load_pend)          pend_q <= c_in;
    end

    for (genvar c = 0; c < sqDim; c++) begin : g_col
        sat_clip #(
            .InW  (OutDataWidth),
            .OutW (OutWordWidth)
        ) u_sat (
            .x_i    (act_q[row_q][c]),
            .y_o    (row_sat[c]),
            .clip_o (clip[c])
        );
    end

    assign out_data_o = out_valid_o ? row_sat : '0;
    assign out_row_o  = row_q;
    assign out_last_o = out_valid_o & last_row;
    assign busy_o     = out_valid_o | pend_full_q;
    assign overflow_o = ovf_q;
    assign sat_o      = sat_q;

endmodule

// File: tb/tb_tile_c_drain.sv
// Scoreboard bench for tile_c_drain: captured tiles are expanded into expected
// saturated rows in a queue; a negedge monitor compares every presented beat.
module tb_tile_c_drain;

    localparam int DW = 32;
    localparam int WW = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, capture, ready;
    logic [N-1:0][N-1:0][DW-1:0] c_in;
    logic                       cap_rdy, valid, last, busy, ovf, sat;
    logic [N-1:0][WW-1:0]       data;
    logic [1:0]                 row;

    tile_c_drain #(.OutDataWidth(DW), .OutWordWidth(WW), .sqDim(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .capture_i     (capture),
        .c_in          (c_in),
        .capture_rdy_o (cap_rdy),
        .out_valid_o   (valid),
        .out_ready_i   (ready),
        .out_data_o    (data),
        .out_row_o     (row),
        .out_last_o    (last),
        .busy_o        (busy),
        .overflow_o    (ovf),
        .sat_o         (sat)
    );

    typedef struct packed {
        logic [N-1:0][WW-1:0] d;
        logic [1:0]           r;
        logic                 last;
        logic                 clip;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    errors  = 0;
    bit    mon_en  = 0;
    bit    exp_ovf = 0;
    bit    exp_sat = 0;
    int    held;
    bit    exp_rdy;
    beat_t f;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed clamp to the 16-bit range.
    task automatic push_tile(input logic [N-1:0][N-1:0][DW-1:0] t);
        beat_t  b;
        longint x, lim_hi, lim_lo;
        lim_hi = 32767;
        lim_lo = -32768;
        for (int r = 0; r < N; r++) begin
            b.clip = 1'b0;
            for (int c = 0; c < N; c++) begin
                x = longint'($signed(t[r][c]));
                if (x > lim_hi) begin x = lim_hi; b.clip = 1'b1; end
                if (x < lim_lo) begin x = lim_lo; b.clip = 1'b1; end
                b.d[c] = WW'(x);
            end
            b.r    = 2'(r);
            b.last = (r == N - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            held    = (exp_q.size() + N - 1) / N;
            exp_rdy = (held < 2);
            check("capture_rdy", longint'(cap_rdy), longint'(exp_rdy));
            check("valid", longint'(valid), longint'(exp_q.size() > 0));
            check("busy", longint'(busy), longint'(exp_q.size() > 0));
            check("overflow", longint'(ovf), longint'(exp_ovf));
            check("sat", longint'(sat), longint'(exp_sat));
            if (!valid) begin
                check("data_idle_zero", longint'(data), 0);
                check("last_idle", longint'(last), 0);
            end else if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_beat: got valid=1 row=%0d, expected no beat", row);
            end else begin
                f = exp_q[0];
                for (int c = 0; c < N; c++)
                    check($sformatf("data_r%0d_c%0d", f.r, c),
                          longint'($signed(data[c])), longint'($signed(f.d[c])));
                check("row", longint'(row), longint'(f.r));
                check("last", longint'(last), longint'(f.last));
                if (ready) begin
                    void'(exp_q.pop_front());
                    if (f.clip) exp_sat = 1;
                end
            end
            if (rst) begin
                exp_q.delete();
                exp_ovf = 0;
                exp_sat = 0;
            end else if (capture) begin
                if (exp_rdy) push_tile(c_in);
                else         exp_ovf = 1;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        step(1);
        capture = 1'b0;
    endtask

    task automatic rand_tile();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                c_in[r][c] = ($urandom_range(0, 2) == 0) ? DW'($urandom)
                                                         : DW'(int'($urandom_range(0, 65535)) - 32768);
    endtask

    initial begin
        rst     = 1'b1;
        capture = 1'b0;
        ready   = 1'b0;
        c_in    = '0;
        step(1);
        mon_en = 1;
        step(2);
        rst = 1'b0;

        // Ramp tile, full-rate drain.
        ready = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                c_in[r][c] = DW'(r * 4 + c);
        pulse_capture();
        step(6);

        // Tile computed as A x B with A[i][j]=i+j+1, B[i][j]=i*j+1.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += (i + k + 1) * (k * j + 1);
                c_in[i][j] = DW'(s);
            end
        pulse_capture();
        step(6);

        // Saturation corners on row 0.
        rand_tile();
        c_in[0][0] = DW'(40000);
        c_in[0][1] = DW'(-40000);
        c_in[0][2] = DW'(32767);
        c_in[0][3] = DW'(-32768);
        pulse_capture();
        step(6);

        // Backpressure pattern 1,0,0,1.
        rand_tile();
        ready = 1'b0;
        pulse_capture();
        for (int i = 0; i < 16; i++) begin
            ready = (i % 4 == 0) || (i % 4 == 3);
            step(1);
        end

        // Fill both slots under stall, then a dropped third capture.
        ready = 1'b0;
        rand_tile();
        pulse_capture();
        step(1);
        rand_tile();
        pulse_capture();
        rand_tile();
        pulse_capture();
        step(2);
        ready = 1'b1;
        step(10);

        // Reset after the row-1 beat, then restart.
        rand_tile();
        pulse_capture();
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        rand_tile();
        pulse_capture();
        step(6);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_tile();
            capture = ($urandom_range(0, 2) == 0);
            ready   = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 150) == 0);
            step(1);
        end
        capture = 1'b0;
        rst     = 1'b0;
        ready   = 1'b1;

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: got %0d rows still expected, expected 0", exp_q.size());
        end
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
